ifu_prefetch_queue: RTL and testbench
=====================================

// Module: ifu_prefetch_queue
// PURPOSE
//  Parametrised instruction-fetch front end: issues sequential fetches on an AXI read channel (AR/R only) with
//  up to MAX_OUT requests in flight and buffers returned instructions in a DEPTH-entry FIFO for decode.
//  Redirects (branch/jump/trap) flush the queue and discard stale in-flight responses without stalling the bus.
//  Sits between the PC-select logic and IDU; replaces the single-request, unbuffered fetch path.
// PARAMETERS
//  ADDR_W    64            address/PC width
//  DATA_W    64            AXI R data width (32 or 64); instruction = 32-bit slice selected by pc[2] when 64
//  DEPTH     4             instruction FIFO entries (power of 2, >=2)
//  MAX_OUT   2             max outstanding AR requests (1..DEPTH)
//  RESET_PC  64'h80000000  fetch address after reset
// PORTS
//  clk           in   1        clock
//  rst           in   1        synchronous reset, active-high
//  redirect_vld  in   1        redirect request, single-cycle pulse
//  redirect_pc   in   ADDR_W   redirect target; bits[1:0] ignored (treated as 0)
//  out_vld       out  1        FIFO head valid
//  out_rdy       in   1        decode accepts head
//  out_pc        out  ADDR_W   PC of head instruction
//  out_inst      out  32       head instruction
//  axi_AR_ADDR   out  ADDR_W   fetch address
//  axi_AR_VALID  out  1        fetch request valid
//  axi_AR_READY  in   1        slave accepts request
//  axi_R_DATA    in   DATA_W   returned data
//  axi_R_VALID   in   1        response valid
//  axi_R_READY   out  1        always 1 (credit scheme guarantees FIFO room)
// BEHAVIOUR
//  - Reset: fetch_pc=resp_pc=RESET_PC, inflight=0, drop_cnt=0, FIFO empty; out_vld=0, axi_AR_VALID=0, axi_R_READY=1.
//  - Credit: may raise AR_VALID when inflight+count<DEPTH and inflight<MAX_OUT; first AR_VALID cycle after rst deasserts.
//  - AR_ADDR = fetch_pc; once AR_VALID=1 it and AR_ADDR hold until AR_READY (AXI rule, even across redirect).
//  - AR fire: fetch_pc+=4, inflight+=1. R fire: inflight-=1. Both in one cycle: inflight unchanged.
//  - R fire, drop_cnt>0: response discarded, drop_cnt-=1, resp_pc unchanged.
//  - R fire, drop_cnt==0: push {resp_pc, inst}; resp_pc+=4; inst = DATA_W==64 ? (resp_pc[2]?R[63:32]:R[31:0]) : R[31:0].
//  - Responses assumed in-order (single ID); PC tag reconstructed from resp_pc, no per-request tag storage.
//  - Latency: R fire in cycle k -> out_vld=1 in cycle k+1 (registered FIFO, no bypass).
//  - Pop on out_vld&&out_rdy; out_pc/out_inst stable while out_vld&&!out_rdy. Push+pop same cycle: count unchanged.
//  - Full: cannot overflow (credit); empty: out_vld=0, out_pc/out_inst don't-care (hold last).
//  - Redirect (priority over push/pop that cycle): FIFO flushed, resp_pc<=redirect_pc;
//    drop_cnt<=inflight after this cycle's AR/R fires (R fire this cycle itself dropped) + pending unaccepted AR;
//    fetch_pc<=redirect_pc, or redirect_pc after the pending stale AR fires; out_vld=0 next cycle.
//  - Back-to-back redirects: last one wins; drop_cnt recomputed from current inflight, never double-counted.
//  - pc wrap-around at 2^ADDR_W wraps silently (modulo add).
//  - rst mid-operation: all state cleared next edge; responses to pre-reset requests are the bench's duty not to send.
// CONFIGURATION
//  IFU_PREFETCH_PERF_EN defined: extra outputs perf_fetch_cnt[31:0] (R fires kept), perf_drop_cnt[31:0] (R fires
//   dropped), perf_stall_cnt[31:0] (cycles out_vld&&!out_rdy); cleared by rst, saturate at 32'hFFFFFFFF.
//  Undefined: ports and counters absent; core behaviour identical.
// TESTING
//  1 Reset, AR_READY=1, R returns 1 cycle after AR -> AR_ADDR 80000000,80000004,...; out_pc/out_inst in order,
//    DATA_W=64 inst alternates R[31:0]/R[63:32].
//  2 out_rdy=0 for 20 cycles -> count reaches DEPTH=4, AR_VALID=0, inflight=0, no overflow; out_rdy=1 drains 4 in order.
//  3 MAX_OUT=2, R latency 5 -> never >2 outstanding; inflight counter never exceeds 2.
//  4 Redirect to 80001000 with 2 in flight -> next 2 R dropped, next out_pc=80001000, no stale inst reaches out.
//  5 Redirect while AR_VALID&&!AR_READY (addr 80000008) -> AR_ADDR held at 80000008, response dropped, then
//    fetch from target.
//  6 PERF_EN: run 3 kept + 2 dropped + 4 stall cycles -> perf counters 3/2/4; rst clears to 0.

Source files
------------

// File: rtl/ifu_prefetch_queue.sv
// ifu_prefetch_queue: sequential instruction prefetcher on an AXI AR/R channel.
// Keeps up to MAX_OUT reads in flight and buffers returned instructions in a
// DEPTH-entry FIFO. A redirect flushes the FIFO. Responses that are still in
// flight are counted and then discarded, so the bus never has to stall.
// Optional feature macro: IFU_PREFETCH_PERF_EN adds saturating perf counters.
module ifu_prefetch_queue #(
  parameter int                ADDR_W   = 64,
  parameter int                DATA_W   = 64,
  parameter int                DEPTH    = 4,
  parameter int                MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_vld,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [ADDR_W-1:0] out_pc,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] axi_AR_ADDR,
  output logic              axi_AR_VALID,
  input  logic              axi_AR_READY,
  input  logic [DATA_W-1:0] axi_R_DATA,
  input  logic              axi_R_VALID,
  output logic              axi_R_READY
`ifdef IFU_PREFETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_drop_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(MAX_OUT + 1);
  localparam int SW = CW + IW;

  logic [ADDR_W-1:0] r_fetch_pc, r_resp_pc, r_redir_pc;
  logic              r_redir_pend;
  logic [IW-1:0]     r_inflight, r_drop_cnt;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [ADDR_W-1:0] r_pc_q   [DEPTH];
  logic [31:0]       r_inst_q [DEPTH];

  logic [SW-1:0]     w_sum;
  logic              w_credit, w_ar_fire, w_ar_stall, w_r_fire, w_keep, w_pop;
  logic [IW-1:0]     w_inflight_nxt, w_drop_nxt;
  logic [ADDR_W-1:0] w_redir_pc;
  logic [31:0]       w_inst;
  logic              w_unused_redir_lsb;

  // Issue only when every outstanding response is guaranteed a FIFO slot.
  // That credit cannot shrink while a request waits, so AR_VALID stays stable.
  assign w_sum        = SW'(r_inflight) + SW'(r_count);
  assign w_credit     = (w_sum < SW'(DEPTH)) && (r_inflight < IW'(MAX_OUT));
  assign axi_AR_VALID = w_credit && !rst;
  assign axi_AR_ADDR  = r_fetch_pc;
  assign axi_R_READY  = 1'b1;

  assign w_ar_fire  = axi_AR_VALID && axi_AR_READY;
  assign w_ar_stall = axi_AR_VALID && !axi_AR_READY;
  assign w_r_fire   = axi_R_VALID;
  assign w_keep     = w_r_fire && (r_drop_cnt == '0) && !redirect_vld;
  assign w_pop      = out_vld && out_rdy && !redirect_vld;
  assign w_redir_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign w_unused_redir_lsb = ^redirect_pc[1:0];

  // Stale responses still owed after a redirect: inflight once this cycle's
  // fires settle, plus a stuck request that must still go out unchanged
  assign w_drop_nxt = w_inflight_nxt + IW'(w_ar_stall);

  // Next in-flight count from this cycle's AR and R handshakes
  always_comb begin
    w_inflight_nxt = r_inflight;
    if (w_ar_fire && !w_r_fire)      w_inflight_nxt = r_inflight + IW'(1);
    else if (!w_ar_fire && w_r_fire) w_inflight_nxt = r_inflight - IW'(1);
  end

  // Pick the 32-bit instruction word from the bus beat using the response PC
  generate
    if (DATA_W == 64) begin : g_sel64
      assign w_inst = r_resp_pc[2] ? axi_R_DATA[63:32] : axi_R_DATA[31:0];
    end else begin : g_sel32
      assign w_inst = axi_R_DATA[31:0];
    end
  endgenerate

  assign out_vld  = (r_count != '0);
  assign out_pc   = r_pc_q[r_rptr];
  assign out_inst = r_inst_q[r_rptr];

  // Fetch/response PCs, credit counters, redirect handling and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc   <= RESET_PC;
      r_resp_pc    <= RESET_PC;
      r_redir_pc   <= RESET_PC;
      r_redir_pend <= 1'b0;
      r_inflight   <= '0;
      r_drop_cnt   <= '0;
      r_count      <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      if (redirect_vld) begin
        r_count    <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_resp_pc  <= w_redir_pc;
        r_drop_cnt <= w_drop_nxt;
        r_redir_pc <= w_redir_pc;
        // A stuck request keeps its address; the target is applied once it fires
        if (w_ar_stall) begin
          r_redir_pend <= 1'b1;
        end else begin
          r_redir_pend <= 1'b0;
          r_fetch_pc   <= w_redir_pc;
        end
      end else begin
        if (w_ar_fire) begin
          r_fetch_pc   <= r_redir_pend ? r_redir_pc : r_fetch_pc + ADDR_W'(4);
          r_redir_pend <= 1'b0;
        end
        if (w_r_fire) begin
          if (r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - IW'(1);
          else                  r_resp_pc  <= r_resp_pc + ADDR_W'(4);
        end
        if (w_keep) r_wptr <= r_wptr + PW'(1);
        if (w_pop)  r_rptr <= r_rptr + PW'(1);
        if (w_keep && !w_pop)      r_count <= r_count + CW'(1);
        else if (!w_keep && w_pop) r_count <= r_count - CW'(1);
      end
    end
  end

  // FIFO payload storage; occupancy is tracked by the pointers above
  always_ff @(posedge clk) begin
    if (w_keep) begin
      r_pc_q[r_wptr]   <= r_resp_pc;
      r_inst_q[r_wptr] <= w_inst;
    end
  end

`ifdef IFU_PREFETCH_PERF_EN
  logic [31:0] r_perf_fetch, r_perf_drop, r_perf_stall;

  // Saturating event counters: kept responses, dropped responses, decode stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch <= '0;
      r_perf_drop  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_keep && (r_perf_fetch != '1)) r_perf_fetch <= r_perf_fetch + 32'd1;
      if (w_r_fire && !w_keep && (r_perf_drop != '1)) r_perf_drop <= r_perf_drop + 32'd1;
      if (out_vld && !out_rdy && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_drop_cnt  = r_perf_drop;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Directed bench for ifu_prefetch_queue: a small in-order AXI read slave
// returns words from an address-derived memory pattern, and each scenario
// task checks the fetch stream against hand-computed PCs and instructions.
module tb_ifu_prefetch_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_vld = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_vld;
  logic        out_rdy = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic [63:0] axi_AR_ADDR;
  logic        axi_AR_VALID;
  logic        axi_AR_READY = 1'b0;
  logic [63:0] axi_R_DATA = '0;
  logic        axi_R_VALID = 1'b0;
  logic        axi_R_READY;
`ifdef IFU_PREFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_drop_cnt, perf_stall_cnt;
`endif

  ifu_prefetch_queue dut (
    .clk(clk), .rst(rst), .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_pc(out_pc), .out_inst(out_inst),
    .axi_AR_ADDR(axi_AR_ADDR), .axi_AR_VALID(axi_AR_VALID), .axi_AR_READY(axi_AR_READY),
    .axi_R_DATA(axi_R_DATA), .axi_R_VALID(axi_R_VALID), .axi_R_READY(axi_R_READY)
`ifdef IFU_PREFETCH_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // slave state
  int          ar_rdy_en = 0;
  int          r_lat = 1;
  int          cyc = 0;
  int          out_cnt = 0;
  int          max_out = 0;
  int          viol = 0;
  logic [63:0] rq_addr[$];
  int          rq_due[$];
  logic [63:0] ar_log[$];
  logic [63:0] pop_pc[$];
  logic [31:0] pop_inst[$];

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [63:0] a8;
    a8 = {a[63:3], 3'b000};
    return {inst_of(a8 + 64'd4), inst_of(a8)};
  endfunction

  // In-order AXI read slave; acts 1 time unit after each negedge
  initial begin
    int rf, af;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        rq_addr.delete();
        rq_due.delete();
        axi_R_VALID = 1'b0;
        out_cnt = 0;
      end else begin
        rf = 0;
        if (rq_addr.size() > 0 && rq_due[0] <= cyc) begin
          axi_R_VALID = 1'b1;
          axi_R_DATA  = mem_word(rq_addr[0]);
          rq_addr.delete(0);
          rq_due.delete(0);
          rf = 1;
        end else begin
          axi_R_VALID = 1'b0;
        end
        axi_AR_READY = (ar_rdy_en != 0);
        af = (axi_AR_VALID && axi_AR_READY) ? 1 : 0;
        if (af != 0) begin
          rq_addr.push_back(axi_AR_ADDR);
          rq_due.push_back(cyc + r_lat);
          ar_log.push_back(axi_AR_ADDR);
        end
        out_cnt = out_cnt + af - rf;
        if (out_cnt > max_out) max_out = out_cnt;
      end
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    max_out = 0;
    viol = 0;
    ar_log.delete();
  endtask

  // Records heads popped by decode, starting with the current cycle
  task automatic collect_pops(input int n, input int maxc, input string nm);
    pop_pc.delete();
    pop_inst.delete();
    for (int c = 0; c < maxc; c++) begin
      if (axi_AR_VALID && out_cnt >= 2) viol++;
      if (out_vld && out_rdy && !redirect_vld) begin
        pop_pc.push_back(out_pc);
        pop_inst.push_back(out_inst);
      end
      if (pop_pc.size() >= n) break;
      @(negedge clk);
    end
    n_chk++;
    if (pop_pc.size() < n)
      $display("FAIL %s_timeout: got %0d pops, need %0d", nm, pop_pc.size(), n);
    else n_pass++;
  endtask

  task automatic test_reset();
    ar_rdy_en = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (out_vld !== 1'b0) $display("FAIL reset_out_vld: got %b exp 0", out_vld); else n_pass++;
    n_chk++; if (axi_AR_VALID !== 1'b0) $display("FAIL reset_ar_valid: got %b exp 0", axi_AR_VALID); else n_pass++;
    n_chk++; if (axi_R_READY !== 1'b1) $display("FAIL reset_r_ready: got %b exp 1", axi_R_READY); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++;
    if (axi_AR_VALID !== 1'b1 || axi_AR_ADDR !== 64'h8000_0000)
      $display("FAIL reset_first_ar: got v=%b a=%h exp v=1 a=80000000", axi_AR_VALID, axi_AR_ADDR);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (axi_AR_VALID !== 1'b1 || axi_AR_ADDR !== 64'h8000_0000)
      $display("FAIL reset_ar_hold: got v=%b a=%h exp v=1 a=80000000", axi_AR_VALID, axi_AR_ADDR);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [63:0] e;
    ar_rdy_en = 1; r_lat = 1; out_rdy = 1'b1;
    do_reset();
    @(negedge clk);
    n_chk++; if (out_vld !== 1'b0) $display("FAIL stream_early_vld: got %b exp 0", out_vld); else n_pass++;
    @(negedge clk);
    n_chk++; if (out_vld !== 1'b1) $display("FAIL stream_latency: got %b exp 1", out_vld); else n_pass++;
    collect_pops(8, 40, "stream");
    for (int i = 0; i < 8 && i < pop_pc.size(); i++) begin
      e = 64'h8000_0000 + 64'(4 * i);
      n_chk++;
      if (pop_pc[i] !== e || pop_inst[i] !== inst_of(e))
        $display("FAIL stream_pop%0d: got pc=%h inst=%h exp pc=%h inst=%h", i, pop_pc[i], pop_inst[i], e, inst_of(e));
      else n_pass++;
    end
    for (int i = 0; i < 4 && i < ar_log.size(); i++) begin
      e = 64'h8000_0000 + 64'(4 * i);
      n_chk++;
      if (ar_log[i] !== e) $display("FAIL stream_ar%0d: got %h exp %h", i, ar_log[i], e); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] e;
    ar_rdy_en = 1; r_lat = 1; out_rdy = 1'b0;
    do_reset();
    repeat (5) @(negedge clk);
    n_chk++;
    if (out_vld !== 1'b1 || out_pc !== 64'h8000_0000)
      $display("FAIL bp_head: got v=%b pc=%h exp v=1 pc=80000000", out_vld, out_pc);
    else n_pass++;
    repeat (15) @(negedge clk);
    n_chk++;
    if (out_pc !== 64'h8000_0000 || out_inst !== inst_of(64'h8000_0000))
      $display("FAIL bp_hold: got pc=%h inst=%h exp pc=80000000 inst=%h", out_pc, out_inst, inst_of(64'h8000_0000));
    else n_pass++;
    n_chk++; if (axi_AR_VALID !== 1'b0) $display("FAIL bp_ar_valid: got %b exp 0", axi_AR_VALID); else n_pass++;
    n_chk++; if (out_cnt != 0) $display("FAIL bp_inflight: got %0d exp 0", out_cnt); else n_pass++;
    n_chk++; if (ar_log.size() != 4) $display("FAIL bp_ar_count: got %0d exp 4", ar_log.size()); else n_pass++;
    out_rdy = 1'b1;
    collect_pops(4, 20, "bp");
    for (int i = 0; i < 4 && i < pop_pc.size(); i++) begin
      e = 64'h8000_0000 + 64'(4 * i);
      n_chk++;
      if (pop_pc[i] !== e || pop_inst[i] !== inst_of(e))
        $display("FAIL bp_drain%0d: got pc=%h inst=%h exp pc=%h inst=%h", i, pop_pc[i], pop_inst[i], e, inst_of(e));
      else n_pass++;
    end
  endtask

  task automatic test_max_out();
    logic [63:0] e;
    ar_rdy_en = 1; r_lat = 5; out_rdy = 1'b1;
    do_reset();
    collect_pops(6, 60, "maxout");
    for (int i = 0; i < 6 && i < pop_pc.size(); i++) begin
      e = 64'h8000_0000 + 64'(4 * i);
      n_chk++;
      if (pop_pc[i] !== e || pop_inst[i] !== inst_of(e))
        $display("FAIL maxout_pop%0d: got pc=%h inst=%h exp pc=%h inst=%h", i, pop_pc[i], pop_inst[i], e, inst_of(e));
      else n_pass++;
    end
    n_chk++; if (max_out != 2) $display("FAIL maxout_peak: got %0d exp 2", max_out); else n_pass++;
    n_chk++; if (viol != 0) $display("FAIL maxout_ar_at_limit: got %0d cycles exp 0", viol); else n_pass++;
  endtask

  task automatic test_redirect();
    ar_rdy_en = 1; r_lat = 5; out_rdy = 1'b1;
    do_reset();
    repeat (2) @(negedge clk);
    n_chk++; if (out_cnt != 2) $display("FAIL redir_inflight: got %0d exp 2", out_cnt); else n_pass++;
    redirect_vld = 1'b1;
    redirect_pc = 64'h8000_1003;
    @(negedge clk);
    redirect_vld = 1'b0;
    n_chk++; if (out_vld !== 1'b0) $display("FAIL redir_out_vld: got %b exp 0", out_vld); else n_pass++;
    collect_pops(3, 40, "redir");
    for (int i = 0; i < 3 && i < pop_pc.size(); i++) begin
      n_chk++;
      if (pop_pc[i] !== 64'h8000_1000 + 64'(4 * i) || pop_inst[i] !== inst_of(64'h8000_1000 + 64'(4 * i)))
        $display("FAIL redir_pop%0d: got pc=%h inst=%h exp pc=%h", i, pop_pc[i], pop_inst[i], 64'h8000_1000 + 64'(4 * i));
      else n_pass++;
    end
    n_chk++;
    if (ar_log.size() < 3 || ar_log[2] !== 64'h8000_1000)
      $display("FAIL redir_ar_target: got n=%0d exp third AR 80001000", ar_log.size());
    else n_pass++;
  endtask

  task automatic test_redirect_stall();
    ar_rdy_en = 1; r_lat = 1; out_rdy = 1'b1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    ar_rdy_en = 0;
    n_chk++;
    if (axi_AR_VALID !== 1'b1 || axi_AR_ADDR !== 64'h8000_0008)
      $display("FAIL stall_ar_pre: got v=%b a=%h exp v=1 a=80000008", axi_AR_VALID, axi_AR_ADDR);
    else n_pass++;
    @(negedge clk);
    redirect_vld = 1'b1;
    redirect_pc = 64'h8000_3000;
    ar_log.delete();
    @(negedge clk);
    redirect_vld = 1'b0;
    n_chk++;
    if (axi_AR_VALID !== 1'b1 || axi_AR_ADDR !== 64'h8000_0008)
      $display("FAIL stall_ar_held: got v=%b a=%h exp v=1 a=80000008", axi_AR_VALID, axi_AR_ADDR);
    else n_pass++;
    n_chk++; if (out_vld !== 1'b0) $display("FAIL stall_flush: got %b exp 0", out_vld); else n_pass++;
    @(negedge clk);
    n_chk++;
    if (axi_AR_ADDR !== 64'h8000_0008) $display("FAIL stall_ar_held2: got %h exp 80000008", axi_AR_ADDR);
    else n_pass++;
    ar_rdy_en = 1;
    collect_pops(2, 30, "stall");
    for (int i = 0; i < 2 && i < pop_pc.size(); i++) begin
      n_chk++;
      if (pop_pc[i] !== 64'h8000_3000 + 64'(4 * i) || pop_inst[i] !== inst_of(64'h8000_3000 + 64'(4 * i)))
        $display("FAIL stall_pop%0d: got pc=%h inst=%h exp pc=%h", i, pop_pc[i], pop_inst[i], 64'h8000_3000 + 64'(4 * i));
      else n_pass++;
    end
    n_chk++;
    if (ar_log.size() < 2 || ar_log[0] !== 64'h8000_0008 || ar_log[1] !== 64'h8000_3000)
      $display("FAIL stall_ar_seq: got n=%0d exp 80000008 then 80003000", ar_log.size());
    else n_pass++;
  endtask

  task automatic test_flush_full();
    ar_rdy_en = 1; r_lat = 1; out_rdy = 1'b0;
    do_reset();
    repeat (8) @(negedge clk);
    n_chk++; if (out_vld !== 1'b1) $display("FAIL flush_full_vld: got %b exp 1", out_vld); else n_pass++;
    redirect_vld = 1'b1;
    redirect_pc = 64'h8000_2000;
    @(negedge clk);
    redirect_vld = 1'b0;
    n_chk++; if (out_vld !== 1'b0) $display("FAIL flush_out_vld: got %b exp 0", out_vld); else n_pass++;
    out_rdy = 1'b1;
    collect_pops(2, 30, "flush");
    for (int i = 0; i < 2 && i < pop_pc.size(); i++) begin
      n_chk++;
      if (pop_pc[i] !== 64'h8000_2000 + 64'(4 * i) || pop_inst[i] !== inst_of(64'h8000_2000 + 64'(4 * i)))
        $display("FAIL flush_pop%0d: got pc=%h inst=%h exp pc=%h", i, pop_pc[i], pop_inst[i], 64'h8000_2000 + 64'(4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    ar_rdy_en = 1; r_lat = 5; out_rdy = 1'b1;
    do_reset();
    repeat (2) @(negedge clk);
    redirect_vld = 1'b1;
    redirect_pc = 64'h8000_4000;
    @(negedge clk);
    redirect_pc = 64'h8000_5000;
    @(negedge clk);
    redirect_vld = 1'b0;
    collect_pops(2, 40, "b2b");
    for (int i = 0; i < 2 && i < pop_pc.size(); i++) begin
      n_chk++;
      if (pop_pc[i] !== 64'h8000_5000 + 64'(4 * i) || pop_inst[i] !== inst_of(64'h8000_5000 + 64'(4 * i)))
        $display("FAIL b2b_pop%0d: got pc=%h inst=%h exp pc=%h", i, pop_pc[i], pop_inst[i], 64'h8000_5000 + 64'(4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [63:0] e;
    ar_rdy_en = 1; r_lat = 1; out_rdy = 1'b1;
    do_reset();
    @(negedge clk);
    redirect_vld = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    redirect_vld = 1'b0;
    collect_pops(3, 30, "wrap");
    for (int i = 0; i < 3 && i < pop_pc.size(); i++) begin
      e = 64'hFFFF_FFFF_FFFF_FFFC + 64'(4 * i);
      n_chk++;
      if (pop_pc[i] !== e || pop_inst[i] !== inst_of(e))
        $display("FAIL wrap_pop%0d: got pc=%h inst=%h exp pc=%h inst=%h", i, pop_pc[i], pop_inst[i], e, inst_of(e));
      else n_pass++;
    end
  endtask

`ifdef IFU_PREFETCH_PERF_EN
  task automatic test_perf();
    ar_rdy_en = 1; r_lat = 5; out_rdy = 1'b0;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    redirect_vld = 1'b1;
    redirect_pc = 64'h8000_6000;
    ar_log.delete();
    @(negedge clk);
    redirect_vld = 1'b0;
    for (int c = 0; c < 60 && !out_vld; c++) begin
      if (ar_log.size() >= 3) ar_rdy_en = 0;
      @(negedge clk);
    end
    repeat (4) begin
      if (ar_log.size() >= 3) ar_rdy_en = 0;
      @(negedge clk);
    end
    out_rdy = 1'b1;
    repeat (30) begin
      if (ar_log.size() >= 3) ar_rdy_en = 0;
      @(negedge clk);
    end
    n_chk++; if (perf_fetch_cnt !== 32'd3) $display("FAIL perf_fetch: got %0d exp 3", perf_fetch_cnt); else n_pass++;
    n_chk++; if (perf_drop_cnt !== 32'd2) $display("FAIL perf_drop: got %0d exp 2", perf_drop_cnt); else n_pass++;
    n_chk++; if (perf_stall_cnt !== 32'd4) $display("FAIL perf_stall: got %0d exp 4", perf_stall_cnt); else n_pass++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (perf_fetch_cnt !== 0 || perf_drop_cnt !== 0 || perf_stall_cnt !== 0)
      $display("FAIL perf_reset: got %0d/%0d/%0d exp 0/0/0", perf_fetch_cnt, perf_drop_cnt, perf_stall_cnt);
    else n_pass++;
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_max_out();
    test_redirect();
    test_redirect_stall();
    test_flush_full();
    test_back_to_back();
    test_wrap();
`ifdef IFU_PREFETCH_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
